serial_adder: RTL and testbench

Bit-serial N-bit adder controller that reuses a single `full_adder` instance to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It sits between a requester presenting parallel operands with a start pulse and the shared one-bit full-adder datapath. It sequences the operand shifting, holds the carry between cycles, assembles the result, and signals completion with a done pulse.

---
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder.  A single one-bit full_adder is reused once per
//   clock, LSB first, to form {carry_out, sum} = a + b + carry_in.
//
// Ports
//   serial_adder_clk       in   clock, rising edge
//   serial_adder_rst_n     in   asynchronous active-low reset
//   serial_adder_start     in   request, sampled only while idle
//   serial_adder_a         in   [WIDTH-1:0] operand A, latched on accepted start
//   serial_adder_b         in   [WIDTH-1:0] operand B, latched on accepted start
//   serial_adder_carry_in  in   initial carry, latched on accepted start
//   serial_adder_busy      out  high while bits are being processed
//   serial_adder_done      out  one-cycle completion pulse
//   serial_adder_sum       out  [WIDTH-1:0] result, held until next completion
//   serial_adder_carry_out out  final carry, held with the sum
//
// Also contains full_adder, the shared one-bit datapath cell.
// -----------------------------------------------------------------------------

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             serial_adder_clk,
   input  logic             serial_adder_rst_n,
   input  logic             serial_adder_start,
   input  logic [WIDTH-1:0] serial_adder_a,
   input  logic [WIDTH-1:0] serial_adder_b,
   input  logic             serial_adder_carry_in,
   output logic             serial_adder_busy,
   output logic             serial_adder_done,
   output logic [WIDTH-1:0] serial_adder_sum,
   output logic             serial_adder_carry_out
);

   // A 1-bit counter is still needed when WIDTH==1 ($clog2(1) is 0).
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_c;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // Result register shifted right with the new sum bit entering at the MSB;
   // after WIDTH shifts the first (LSB) bit has reached bit 0.  Written as a
   // shift plus bit overwrite so WIDTH==1 needs no special-case slicing.
   always_comb begin
      res_next            = res_sh >> 1;
      res_next[WIDTH-1]   = fa_s;
   end

   always_ff @(posedge serial_adder_clk or negedge serial_adder_rst_n) begin
      if (!serial_adder_rst_n) begin
         state                  <= IDLE;
         a_sh                   <= '0;
         b_sh                   <= '0;
         res_sh                 <= '0;
         carry                  <= 1'b0;
         cnt                    <= '0;
         serial_adder_busy      <= 1'b0;
         serial_adder_done      <= 1'b0;
         serial_adder_sum       <= '0;
         serial_adder_carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               serial_adder_done <= 1'b0;
               if (serial_adder_start) begin
                  a_sh              <= serial_adder_a;
                  b_sh              <= serial_adder_b;
                  carry             <= serial_adder_carry_in;
                  res_sh            <= '0;
                  cnt               <= '0;
                  serial_adder_busy <= 1'b1;
                  state             <= RUN;
               end
            end

            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               carry  <= fa_c;
               cnt    <= cnt + 1'b1;
               // Last bit: publish the completed result on this same edge.
               if (cnt == LAST_BIT) begin
                  serial_adder_sum       <= res_next;
                  serial_adder_carry_out <= fa_c;
                  serial_adder_busy      <= 1'b0;
                  serial_adder_done      <= 1'b1;
                  state                  <= DONE;
               end
            end

            DONE: begin
               // Start is deliberately ignored here.
               serial_adder_done <= 1'b0;
               state             <= IDLE;
            end

            default: begin
               serial_adder_busy <= 1'b0;
               serial_adder_done <= 1'b0;
               state             <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed self-checking bench for serial_adder with WIDTH=8.
// -----------------------------------------------------------------------------

module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         co;

   int n_cmp;
   int n_err;

   serial_adder #(.WIDTH(W)) dut (
      .serial_adder_clk       (clk),
      .serial_adder_rst_n     (rst_n),
      .serial_adder_start     (start),
      .serial_adder_a         (a),
      .serial_adder_b         (b),
      .serial_adder_carry_in  (cin),
      .serial_adder_busy      (busy),
      .serial_adder_done      (done),
      .serial_adder_sum       (sum),
      .serial_adder_carry_out (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Full operation; entered and left at posedge+1 with the DUT idle.
   task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb,
                         input logic opc, input logic [W-1:0] exp_sum,
                         input logic exp_co, input string nm);
      logic [W-1:0] old_sum;
      logic         old_co;
      old_sum = sum;
      old_co  = co;
      a = opa; b = opb; cin = opc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'h5A; b = 8'hC3; cin = ~opc;   // must have no effect after accept
      for (int i = 1; i <= W; i++) begin
         n_cmp++;
         if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL %s run cycle %0d busy/done: got %b%b want 10", nm, i, busy, done);
         end
         n_cmp++;
         if ({co, sum} !== {old_co, old_sum}) begin
            n_err++;
            $display("FAIL %s early result cycle %0d: got %h want %h", nm, i, {co, sum}, {old_co, old_sum});
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if ({busy, done} !== 2'b01) begin
         n_err++;
         $display("FAIL %s done cycle busy/done: got %b%b want 01", nm, busy, done);
      end
      n_cmp++;
      if ({co, sum} !== {exp_co, exp_sum}) begin
         n_err++;
         $display("FAIL %s result: got %h want %h", nm, {co, sum}, {exp_co, exp_sum});
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, co, sum} !== {2'b00, exp_co, exp_sum}) begin
         n_err++;
         $display("FAIL %s after done: got %h want %h", nm, {busy, done, co, sum}, {2'b00, exp_co, exp_sum});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #2 rst_n = 1'b0;
      start = 1'b1; a = 8'hA5; b = 8'h3C; cin = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, co, sum} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_hold: got %h want 000", {busy, done, co, sum});
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({busy, done, co, sum} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_release cycle %0d: got %h want 000", i, {busy, done, co, sum});
         end
      end
   endtask

   task automatic test_basic();
      run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "basic");
   endtask

   task automatic test_carry_chain();
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_ff_01");
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "carry_ff_ff_1");
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "carry_msb");
      run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "carry_in_only");
   endtask

   task automatic test_ignored_start();
      int n_done;
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;               // accepted
      a = 8'hAA; b = 8'h55;             // start stays high through RUN and DONE
      n_done = 0;
      for (int i = 0; i < W + 1; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
         if (i == W - 1) begin
            n_cmp++;
            if ({co, sum} !== 9'h046) begin
               n_err++;
               $display("FAIL ignored_start result: got %h want 046", {co, sum});
            end
         end
      end
      start = 1'b0;                     // now idle; drop start before it is sampled
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL ignored_start idle %0d busy/done: got %b%b want 00", i, busy, done);
         end
      end
      n_cmp++;
      if (n_done !== 1) begin
         n_err++;
         $display("FAIL ignored_start done count: got %0d want 1", n_done);
      end
   endtask

   task automatic test_reset_mid_op();
      a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;               // edge k
      start = 1'b0;
      repeat (4) @(posedge clk);        // edge k+4
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, co, sum} !== 11'd0) begin
         n_err++;
         $display("FAIL midop_async_clear: got %h want 000", {busy, done, co, sum});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({busy, done, co, sum} !== 11'd0) begin
            n_err++;
            $display("FAIL midop_no_done cycle %0d: got %h want 000", i, {busy, done, co, sum});
         end
      end
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_midop_reset");
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ea, eb;
      logic         ec;
      logic [W:0]   exp;
      int           lat;
      start = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         ea = W'($urandom); eb = W'($urandom); ec = 1'($urandom);
         a = ea; b = eb; cin = ec;
         exp = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
         @(posedge clk); #1;            // accepting edge
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         n_cmp++;
         if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b %0d accept busy: got %b want 1", n, busy);
         end
         lat = 0;
         while (done !== 1'b1 && lat < W + 4) begin
            @(posedge clk); #1;
            lat++;
         end
         n_cmp++;
         if (lat !== W) begin
            n_err++;
            $display("FAIL b2b %0d latency: got %0d want %0d", n, lat, W);
         end
         n_cmp++;
         if ({co, sum} !== exp) begin
            n_err++;
            $display("FAIL b2b %0d result a=%h b=%h c=%b: got %h want %h", n, ea, eb, ec, {co, sum}, exp);
         end
         @(posedge clk); #1;            // DONE -> IDLE, start ignored
         a = W'($urandom);
      end
      start = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_carry_chain();
      test_ignored_start();
      test_reset_mid_op();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
